// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Brief   : Shared CPU datapath types and constants (multiplier FSM states). |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/booth_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : booth_addsub                                                     |
// | Brief   : Booth step adder: A+M, A-M or A selected by {Q[0], q_1}.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module booth_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_m,
    input  logic [1:0]     i_sel,
    output logic [WIDTH:0] o_sum
);

    always_comb begin
        o_sum = i_a;
        case (i_sel)
            2'b01:   o_sum = i_a + i_m;
            2'b10:   o_sum = i_a - i_m;
            default: o_sum = i_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : booth_mul                                                        |
// | Brief   : Sequential radix-2 Booth multiplier, MR x BR -> 2*WIDTH product. |
// |           Optional macro BOOTH_EARLY_EXIT_EN enables early termination.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module booth_mul
    import cpu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mr_in,
    input  logic [WIDTH-1:0]     br_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 neg,
    output logic                 zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 2 * WIDTH + 2;

    mul_state_t           r_state;
    mul_state_t           w_state_next;
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_m;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q1;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_sum;
    logic [SW-1:0]        w_stepped;
    logic [SW-1:0]        w_shifted;
    logic [CW-1:0]        w_shamt;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_load;

    booth_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a   (r_a),
        .i_m   (r_m),
        .i_sel ({r_q[0], r_q1}),
        .o_sum (w_sum)
    );

    assign w_stepped = {w_sum, r_q, r_q1};

`ifdef BOOTH_EARLY_EXIT_EN
    // Looks one step ahead: once the Q bits still to be scanned after this step
    // all match the bit that becomes q_1, no further add/sub can happen, so the
    // remaining shifts collapse into one.
    logic [WIDTH-1:0] w_mask;
    logic             w_exit;

    assign w_mask    = WIDTH'(({{WIDTH{1'b0}}, 1'b1} << r_cnt) - 1'b1);
    assign w_exit    = ((r_q ^ {WIDTH{r_q[0]}}) & w_mask) == '0;
    assign w_shamt   = w_exit ? r_cnt : CW'(1);
    assign w_shifted = $signed(w_stepped) >>> w_shamt;
`else
    assign w_shamt   = CW'(1);
    assign w_shifted = {w_sum[WIDTH], w_stepped[SW-1:1]};
`endif

    assign w_cnt_next = r_cnt - w_shamt;
    assign w_load     = (r_state == IDLE || r_state == DONE) && start;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_cnt_next == '0) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_a   <= '0;
            r_m   <= {br_in[WIDTH-1], br_in};
            r_q   <= mr_in;
            r_q1  <= 1'b0;
            r_cnt <= CW'(WIDTH);
        end else if (r_state == RUN) begin
            r_a   <= w_shifted[SW-1:WIDTH+1];
            r_q   <= w_shifted[WIDTH:1];
            r_q1  <= w_shifted[0];
            r_cnt <= w_cnt_next;
            if (w_cnt_next == '0) begin
                r_product <= w_shifted[2*WIDTH:1];
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;
    assign neg     = r_product[2*WIDTH-1];
    assign zero    = (r_product == '0);

endmodule
`default_nettype wire

// File: tb/tb_booth_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_booth_mul                                                     |
// | Brief   : Directed self-checking bench for booth_mul.                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_booth_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mr_in;
    logic [15:0] br_in;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        neg;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mul #(
        .WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mr_in   (mr_in),
        .br_in   (br_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .neg     (neg),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected latency in edges after acceptance; -1 means not checked in that build.
    function automatic int lat_of(input int fixed_lat, input int early_lat);
`ifdef BOOTH_EARLY_EXIT_EN
        return early_lat;
`else
        return fixed_lat;
`endif
    endfunction

    task automatic launch(input logic [15:0] mr, input logic [15:0] br);
        start = 1'b1;
        mr_in = mr;
        br_in = br;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] mr, input logic [15:0] br,
                           input logic [31:0] exp, input int exp_lat);
        int lat;
        launch(mr, br);
        check({tag, " busy"}, 64'(busy), 64'(1));
        check({tag, " done_low"}, 64'(done), 64'(0));
        wait_done(lat);
        check({tag, " done_seen"}, 64'(done), 64'(1));
        if (exp_lat >= 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_in_done"}, 64'(busy), 64'(0));
        check({tag, " product"}, 64'(product), 64'(exp));
        check({tag, " neg"}, 64'(neg), 64'(exp[31]));
        check({tag, " zero"}, 64'(zero), 64'(exp == 32'h0));
    endtask

    task automatic end_pulse(input string tag);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int lat;
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        mr_in = '0;
        br_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst product", 64'(product), 64'(0));
        check("rst neg", 64'(neg), 64'(0));
        check("rst zero", 64'(zero), 64'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_vec("3x5", 16'd3, 16'd5, 32'h0000_000F, lat_of(16, 3));
        end_pulse("3x5");
        run_vec("m7x6", 16'hFFF9, 16'd6, 32'hFFFF_FFD6, lat_of(16, -1));
        end_pulse("m7x6");
        run_vec("minxmin", 16'h8000, 16'h8000, 32'h4000_0000, lat_of(16, 16));
        end_pulse("minxmin");
        run_vec("maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000, lat_of(16, 16));
        end_pulse("maxxmin");
        run_vec("m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001, lat_of(16, 1));
        end_pulse("m1xm1");
        run_vec("x0", 16'h1234, 16'h0000, 32'h0000_0000, lat_of(16, -1));
        end_pulse("x0");
        run_vec("mr0", 16'h0000, 16'h1234, 32'h0000_0000, lat_of(16, 1));
        end_pulse("mr0");
        run_vec("mr1", 16'h0001, 16'h1234, 32'h0000_1234, lat_of(16, 2));
        end_pulse("mr1");

        // Back-to-back: second start lands in the DONE cycle of the first.
        run_vec("b2b_a", 16'd3, 16'd5, 32'h0000_000F, lat_of(16, 3));
        run_vec("b2b_b", 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, lat_of(16, 16));
        end_pulse("b2b_b");

        // Start pulse in RUN cycle 5 must be ignored.
        launch(16'h8000, 16'h0003);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        mr_in = 16'h0001;
        br_in = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign busy", 64'(busy), 64'(1));
        wait_done(lat);
        check("ign done_seen", 64'(done), 64'(1));
        check("ign latency", 64'(lat + 5), 64'(lat_of(16, 16)));
        check("ign product", 64'(product), 64'(32'hFFFE_8000));
        check("ign neg", 64'(neg), 64'(1));
        end_pulse("ign");

        // Reset in RUN cycle 8 aborts without a done pulse.
        launch(16'h7FFF, 16'h7FFF);
        repeat (7) @(posedge clk);
        #1;
        check("abort busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort product", 64'(product), 64'(0));
        check("abort zero", 64'(zero), 64'(1));
        check("abort neg", 64'(neg), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("abort no_done", 64'(done_seen), 64'(0));

        // Normal operation resumes after the abort.
        run_vec("post", 16'hFFF9, 16'h0006, 32'hFFFF_FFD6, lat_of(16, -1));
        end_pulse("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
